// File: rtl/ff_pkg.sv
// Shared definitions for the configurable flip-flop bank: mode encoding and
// the single-bit next-state function used by every channel.
package ff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } ff_mode_e;

  typedef struct packed {
    logic next_q;
    logic err;
  } ff_next_t;

  // err flags the SR forbidden input; q is held in that case.
  function automatic ff_next_t ff_next(ff_mode_e mode, logic a, logic b, logic q);
    ff_next_t r;
    r.next_q = q;
    r.err    = 1'b0;
    case (mode)
      MODE_D:  r.next_q = a;
      MODE_T:  r.next_q = q ^ a;
      MODE_JK: begin
        case ({a, b})
          2'b10:   r.next_q = 1'b1;
          2'b01:   r.next_q = 1'b0;
          2'b11:   r.next_q = ~q;
          default: r.next_q = q;
        endcase
      end
      MODE_SR: begin
        case ({a, b})
          2'b10:   r.next_q = 1'b1;
          2'b01:   r.next_q = 1'b0;
          2'b11:   r.err    = 1'b1;
          default: r.next_q = q;
        endcase
      end
      default: r.next_q = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One channel of the flip-flop bank: state bit, change strobe and sticky
// SR-forbidden flag.
module ff_cell
  import ff_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       clr_err,
  output logic       q,
  output logic       changed,
  output logic       sr_err
);

  logic     r_q;
  logic     r_changed;
  logic     r_sr_err;
  ff_next_t w_nxt;

  assign w_nxt = ff_next(ff_mode_e'(mode), a, b, r_q);

  // A new error on this edge wins over clr_err.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q       <= RST_BIT;
      r_changed <= 1'b0;
      r_sr_err  <= 1'b0;
    end else if (en) begin
      r_q       <= w_nxt.next_q;
      r_changed <= w_nxt.next_q ^ r_q;
      r_sr_err  <= w_nxt.err | (r_sr_err & ~clr_err);
    end else begin
      r_changed <= 1'b0;
      r_sr_err  <= r_sr_err & ~clr_err;
    end
  end

  assign q       = r_q;
  assign changed = r_changed;
  assign sr_err  = r_sr_err;

endmodule

// File: rtl/ff_bank_cfg.sv
// WIDTH independent flip-flops with run-time D/T/JK/SR mode, global enable,
// per-bit change strobe and sticky SR-forbidden flags.
module ff_bank_cfg
  import ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] sr_err
);

  logic [WIDTH-1:0] w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RST_BIT(RST_VAL[i])
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .clr_err (clr_err),
      .q       (w_q[i]),
      .changed (changed[i]),
      .sr_err  (sr_err[i])
    );
  end

  assign q    = w_q;
  assign qbar = ~w_q;

endmodule

// File: tb/tb_ff_bank_cfg.sv
// Self-checking bench for ff_bank_cfg: directed vector table plus a
// randomized phase against a bitwise reference model, both via a scoreboard.
module tb_ff_bank_cfg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic       rnd;
    logic [7:0] eq;
    logic [7:0] ech;
    logic [7:0] eerr;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] ch;
    logic [7:0] err;
    int         tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, clr_err;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic [7:0] q, qbar, changed, sr_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  exp_t sb[$];
  logic [7:0] m_q, m_err;

  always #5 clk = ~clk;

  ff_bank_cfg #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .clr_err(clr_err), .q(q), .qbar(qbar), .changed(changed), .sr_err(sr_err)
  );

  function automatic vec_t mk(logic r, logic e, logic [1:0] m, logic [7:0] va,
                              logic [7:0] vb, logic c, logic rn, logic [7:0] eq,
                              logic [7:0] ech, logic [7:0] eerr);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.a = va; v.b = vb; v.clr = c; v.rnd = rn;
    v.eq = eq; v.ech = ech; v.eerr = eerr;
    return v;
  endfunction

  task automatic cmp8(string nm, int tag, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: empty queue at %0t", $time);
    end else begin
      e = sb.pop_front();
      cmp8("q", e.tag, q, e.q);
      cmp8("qbar", e.tag, qbar, ~e.q);
      cmp8("changed", e.tag, changed, e.ch);
      cmp8("sr_err", e.tag, sr_err, e.err);
    end
  endtask

  task automatic drive(logic r, logic e, logic [1:0] m, logic [7:0] va,
                       logic [7:0] vb, logic c);
    @(negedge clk);
    rst = r; en = e; mode = m; a = va; b = vb; clr_err = c;
  endtask

  // Reference model written as whole-vector boolean equations.
  task automatic model_step(logic r, logic e, logic [1:0] m, logic [7:0] va,
                            logic [7:0] vb, logic c, output logic [7:0] ch);
    logic [7:0] nq, nerr;
    nq = m_q; nerr = 8'h00; ch = 8'h00;
    case (m)
      2'd0: nq = va;
      2'd1: nq = m_q ^ va;
      2'd2: nq = (va & ~m_q) | (~vb & m_q);
      default: begin
        nq   = (va & ~vb) | (m_q & ~(~va & vb));
        nerr = va & vb;
      end
    endcase
    if (!r) begin
      m_q = RV; m_err = 8'h00;
    end else if (e) begin
      ch = nq ^ m_q; m_q = nq; m_err = nerr | (m_err & ~{8{c}});
    end else begin
      m_err = m_err & ~{8{c}};
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    logic [7:0] ch;
    rst = 1'b0; en = 1'b0; mode = 2'd0; a = '0; b = '0; clr_err = 1'b0;

    // reset with random operands, release, then T/JK/SR/enable/reset sequences
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'hA5, 8'h00, 8'h00));
    vecs.push_back(mk(0, 0, 3, 0, 0, 1, 1, 8'hA5, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'hA5, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h0F, 8'h00, 0, 0, 8'h0F, 8'h0F, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h0F, 8'h00, 0, 0, 8'h00, 8'h0F, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h0F, 8'h00, 0, 0, 8'h0F, 8'h0F, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h00, 8'hFF, 0, 0, 8'h0F, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h0F, 8'h00));
    vecs.push_back(mk(1, 1, 2, 8'hF0, 8'h00, 0, 0, 8'hF0, 8'hF0, 8'h00));
    vecs.push_back(mk(1, 1, 2, 8'h00, 8'h30, 0, 0, 8'hC0, 8'h30, 8'h00));
    vecs.push_back(mk(1, 1, 2, 8'hFF, 8'hFF, 0, 0, 8'h3F, 8'hFF, 8'h00));
    vecs.push_back(mk(1, 1, 2, 8'h00, 8'h00, 0, 0, 8'h3F, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 0, 8'h0F, 8'h00, 0, 0, 8'h0F, 8'h30, 8'h00));
    vecs.push_back(mk(1, 1, 3, 8'h11, 8'h03, 0, 0, 8'h1D, 8'h12, 8'h01));
    vecs.push_back(mk(1, 1, 3, 8'h02, 8'h02, 1, 0, 8'h1D, 8'h00, 8'h02));
    vecs.push_back(mk(1, 0, 3, 8'hFF, 8'hFF, 1, 0, 8'h1D, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 3, 8'h80, 8'h80, 0, 0, 8'h1D, 8'h00, 8'h80));
    vecs.push_back(mk(1, 0, 0, 8'h11, 8'h00, 0, 0, 8'h1D, 8'h00, 8'h80));
    vecs.push_back(mk(1, 0, 0, 8'h22, 8'h00, 0, 0, 8'h1D, 8'h00, 8'h80));
    vecs.push_back(mk(1, 0, 0, 8'h33, 8'h00, 0, 0, 8'h1D, 8'h00, 8'h80));
    vecs.push_back(mk(1, 0, 0, 8'h44, 8'h00, 0, 0, 8'h1D, 8'h00, 8'h80));
    vecs.push_back(mk(1, 1, 0, 8'h55, 8'h00, 0, 0, 8'h55, 8'h48, 8'h80));
    vecs.push_back(mk(1, 1, 0, 8'hFF, 8'h00, 0, 0, 8'hFF, 8'hAA, 8'h80));
    vecs.push_back(mk(1, 1, 1, 8'hFF, 8'h00, 0, 0, 8'h00, 8'hFF, 8'h80));
    vecs.push_back(mk(1, 1, 1, 8'hFF, 8'h00, 0, 0, 8'hFF, 8'hFF, 8'h80));
    vecs.push_back(mk(0, 1, 1, 8'hFF, 8'h00, 0, 0, 8'hA5, 8'h00, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'hFF, 8'h00, 0, 0, 8'h5A, 8'hFF, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rnd) begin
        v.a  = 8'($urandom);
        v.b  = 8'($urandom);
        v.en = 1'($urandom);
      end
      drive(v.rst, v.en, v.mode, v.a, v.b, v.clr);
      e.q = v.eq; e.ch = v.ech; e.err = v.eerr; e.tag = i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
    end

    // Random phase: model state continues from the last directed vector.
    m_q = 8'h5A; m_err = 8'h00;
    for (int i = 0; i < 300; i++) begin
      v.rst  = ($urandom_range(0, 19) != 0);
      v.en   = ($urandom_range(0, 3) != 0);
      v.mode = 2'($urandom_range(0, 3));
      v.a    = 8'($urandom);
      v.b    = 8'($urandom);
      v.clr  = ($urandom_range(0, 7) == 0);
      drive(v.rst, v.en, v.mode, v.a, v.b, v.clr);
      model_step(v.rst, v.en, v.mode, v.a, v.b, v.clr, ch);
      e.q = m_q; e.ch = ch; e.err = m_err; e.tag = 1000 + i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
    end

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
